// File: rtl/pe_pkg.sv
// pe_pkg: shared definitions for the pe_v3 processing element.
//   - mode_t  : job accumulation mode as carried on cfg_mode
//   - state_t : controller state encoding
//   - DEF_*   : default widths of the standard ViT build
//   - ACC_MIN/ACC_MAX, OUT_MIN/OUT_MAX : signed bounds for the default build
//     (modules derive their own bounds from their actual parameters)
package pe_pkg;

  typedef enum logic [1:0] {
    MODE_MACC = 2'd0,
    MODE_ADD  = 2'd1,
    MODE_MAX  = 2'd2,
    MODE_ILL  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_QUANT = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_NUM_MACS    = 64;
  localparam int DEF_ACC_WIDTH   = 24;
  localparam int DEF_K_WIDTH     = 10;
  localparam int DEF_SHIFT_WIDTH = 5;

  localparam logic signed [DEF_ACC_WIDTH-1:0] ACC_MIN =
    {1'b1, {(DEF_ACC_WIDTH-1){1'b0}}};
  localparam logic signed [DEF_ACC_WIDTH-1:0] ACC_MAX =
    {1'b0, {(DEF_ACC_WIDTH-1){1'b1}}};
  localparam logic signed [DEF_DATA_WIDTH-1:0] OUT_MIN =
    {1'b1, {(DEF_DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DEF_DATA_WIDTH-1:0] OUT_MAX =
    {1'b0, {(DEF_DATA_WIDTH-1){1'b1}}};

endpackage

// File: rtl/pe_lane.sv
// pe_lane: one signed lane of the processing element.
// Holds the lane accumulator, selects the per-mode update (MACC, ADD, MAX),
// saturates at the accumulator bounds, and requantises to DATA_WIDTH with
// round-half-up and clipping into a registered output.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   init_en    job accepted: load initial accumulator value
//   init_max   initial value is the most negative DATA_WIDTH value (MAX jobs)
//   beat_en    accepted input beat: update accumulator (lane clock enable)
//   mode       latched job mode
//   a, b       lane operand and broadcast operand
//   quant_en   requantise accumulator into o
//   shift      latched requantisation shift
//   o          registered requantised result
//   sat, clip  single-cycle event flags: saturation on this beat / clip at requant
module pe_lane
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          init_en,
  input  logic                          init_max,
  input  logic                          beat_en,
  input  mode_t                         mode,
  input  logic signed [DATA_WIDTH-1:0]  a,
  input  logic signed [DATA_WIDTH-1:0]  b,
  input  logic                          quant_en,
  input  logic        [SHIFT_WIDTH-1:0] shift,
  output logic signed [DATA_WIDTH-1:0]  o,
  output logic                          sat,
  output logic                          clip
);

  localparam logic signed [ACC_WIDTH-1:0] ACC_LO = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_HI = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MAX_INIT =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH:0] OUT_LO =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH:0] OUT_HI =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};

  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [ACC_WIDTH-1:0]    acc_next;
  logic signed [ACC_WIDTH-1:0]    a_ext;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH:0]      addend;
  logic signed [ACC_WIDTH:0]      sum;
  logic                           sum_ovf;

  logic signed [ACC_WIDTH:0]      acc_x;
  logic        [SHIFT_WIDTH-1:0]  shift_m1;
  logic signed [ACC_WIDTH:0]      rnd;
  logic signed [ACC_WIDTH:0]      rounded;
  logic signed [ACC_WIDTH:0]      shifted;
  logic signed [ACC_WIDTH:0]      req;
  logic signed [DATA_WIDTH-1:0]   o_next;
  logic                           clip_c;

  assign prod  = a * b;
  assign a_ext = {{(ACC_WIDTH-DATA_WIDTH){a[DATA_WIDTH-1]}}, a};

  // Accumulator update. The sum is formed one bit wider than the accumulator
  // so signed overflow shows up as a mismatch of the two top bits.
  always_comb begin
    addend = '0;
    case (mode)
      MODE_MACC: addend = {{(ACC_WIDTH+1-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
      MODE_ADD:  addend = {{(ACC_WIDTH+1-DATA_WIDTH){a[DATA_WIDTH-1]}}, a};
      default:   addend = '0;
    endcase
    sum     = {acc[ACC_WIDTH-1], acc} + addend;
    sum_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    if (mode == MODE_MAX) begin
      acc_next = (a_ext > acc) ? a_ext : acc;
    end else if (sum_ovf) begin
      acc_next = sum[ACC_WIDTH] ? ACC_LO : ACC_HI;
    end else begin
      acc_next = sum[ACC_WIDTH-1:0];
    end
  end

  assign sat = beat_en & sum_ovf;

  // Requantisation. Shifts wider than the accumulator always round to zero,
  // and the rounding constant for them would not fit ACC_WIDTH+1 bits, so
  // that case is forced to zero explicitly.
  always_comb begin
    acc_x    = {acc[ACC_WIDTH-1], acc};
    shift_m1 = shift - SHIFT_WIDTH'(1);
    rnd      = (ACC_WIDTH+1)'(1) << shift_m1;
    rounded  = acc_x + rnd;
    shifted  = rounded >>> shift;
    if (shift == '0) begin
      req = acc_x;
    end else if (int'(shift) > ACC_WIDTH) begin
      req = '0;
    end else begin
      req = shifted;
    end
    clip_c = 1'b0;
    o_next = req[DATA_WIDTH-1:0];
    if (req > OUT_HI) begin
      o_next = OUT_HI[DATA_WIDTH-1:0];
      clip_c = 1'b1;
    end else if (req < OUT_LO) begin
      o_next = OUT_LO[DATA_WIDTH-1:0];
      clip_c = 1'b1;
    end
  end

  assign clip = quant_en & clip_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      o   <= '0;
    end else begin
      if (init_en) begin
        acc <= init_max ? MAX_INIT : '0;
      end else if (beat_en) begin
        acc <= acc_next;
      end
      if (quant_en) begin
        o <= o_next;
      end
    end
  end

endmodule

// File: rtl/pe_v3.sv
// pe_v3: NUM_MACS-lane processing element with valid/ready job control.
// A job is configured (mode, beat count, shift), accumulates cfg_k input
// beats in every lane, requantises all lanes in one cycle, and presents the
// packed result until the consumer accepts it.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cfg_valid/cfg_ready      config handshake (ready only in IDLE)
//   cfg_mode/cfg_k/cfg_shift job mode, beats per job, requant shift
//   cfg_err                  one-cycle pulse on an illegal config
//   in_valid/in_ready        input beat handshake
//   a_packed, b              per-lane operands and broadcast operand
//   out_valid/out_ready      result handshake
//   o_packed                 requantised result, lane j at [j*DATA_WIDTH +: DATA_WIDTH]
//   ovf                      sticky saturation/clip flag for the current job
//   busy                     controller not idle
module pe_v3
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int NUM_MACS    = DEF_NUM_MACS,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int K_WIDTH     = DEF_K_WIDTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic [1:0]                       cfg_mode,
  input  logic [K_WIDTH-1:0]               cfg_k,
  input  logic [SHIFT_WIDTH-1:0]           cfg_shift,
  output logic                             cfg_err,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_MACS*DATA_WIDTH-1:0]   a_packed,
  input  logic signed [DATA_WIDTH-1:0]     b,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_MACS*DATA_WIDTH-1:0]   o_packed,
  output logic                             ovf,
  output logic                             busy
);

  state_t                   state;
  mode_t                    mode_q;
  logic [K_WIDTH-1:0]       k_q;
  logic [SHIFT_WIDTH-1:0]   shift_q;
  logic [K_WIDTH-1:0]       beat_cnt;
  logic [K_WIDTH:0]         cnt_next;
  logic                     last_beat;
  logic                     cfg_illegal;
  logic                     cfg_accept;
  logic                     cfg_is_max;
  logic                     beat_en;
  logic                     quant_en;
  logic [NUM_MACS-1:0]      sat_vec;
  logic [NUM_MACS-1:0]      clip_vec;

  assign cfg_illegal = (cfg_mode == MODE_ILL) || (cfg_k == '0);
  assign cfg_accept  = cfg_valid & cfg_ready & ~cfg_illegal;
  assign cfg_is_max  = (cfg_mode == MODE_MAX);
  assign beat_en     = in_valid & in_ready;
  assign quant_en    = (state == ST_QUANT);

  // One extra bit keeps the compare exact for k = 2^K_WIDTH-1.
  assign cnt_next  = {1'b0, beat_cnt} + (K_WIDTH+1)'(1);
  assign last_beat = (cnt_next == {1'b0, k_q});

  // Controller: state, config registers, beat counter, sticky ovf and all
  // handshake outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_MACC;
      k_q       <= '0;
      shift_q   <= '0;
      beat_cnt  <= '0;
      cfg_ready <= 1'b1;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      cfg_err   <= 1'b0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_valid) begin
            if (cfg_illegal) begin
              cfg_err <= 1'b1;
            end else begin
              mode_q    <= mode_t'(cfg_mode);
              k_q       <= cfg_k;
              shift_q   <= cfg_shift;
              beat_cnt  <= '0;
              ovf       <= 1'b0;
              state     <= ST_ACCUM;
              cfg_ready <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end
        ST_ACCUM: begin
          if (in_valid) begin
            beat_cnt <= cnt_next[K_WIDTH-1:0];
            ovf      <= ovf | (|sat_vec);
            if (last_beat) begin
              state    <= ST_QUANT;
              in_ready <= 1'b0;
            end
          end
        end
        ST_QUANT: begin
          ovf       <= ovf | (|clip_vec);
          state     <= ST_OUT;
          out_valid <= 1'b1;
        end
        ST_OUT: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar j = 0; j < NUM_MACS; j++) begin : g_lane
    pe_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .init_en (cfg_accept),
      .init_max(cfg_is_max),
      .beat_en (beat_en),
      .mode    (mode_q),
      .a       (a_packed[j*DATA_WIDTH +: DATA_WIDTH]),
      .b       (b),
      .quant_en(quant_en),
      .shift   (shift_q),
      .o       (o_packed[j*DATA_WIDTH +: DATA_WIDTH]),
      .sat     (sat_vec[j]),
      .clip    (clip_vec[j])
    );
  end

endmodule

// File: tb/tb_pe_v3.sv
// tb_pe_v3: self-checking bench for pe_v3 with a behavioural per-lane model.
module tb_pe_v3;

  localparam int DW = 8;
  localparam int NM = 64;
  localparam int AW = 24;
  localparam int KW = 10;
  localparam int SW = 5;

  localparam longint ACC_HI = (longint'(1) << (AW-1)) - 1;
  localparam longint ACC_LO = -(longint'(1) << (AW-1));
  localparam longint OUT_HI = (longint'(1) << (DW-1)) - 1;
  localparam longint OUT_LO = -(longint'(1) << (DW-1));

  logic               clk;
  logic               rst;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [1:0]         cfg_mode;
  logic [KW-1:0]      cfg_k;
  logic [SW-1:0]      cfg_shift;
  logic               cfg_err;
  logic               in_valid;
  logic               in_ready;
  logic [NM*DW-1:0]   a_packed;
  logic [DW-1:0]      b;
  logic               out_valid;
  logic               out_ready;
  logic [NM*DW-1:0]   o_packed;
  logic               ovf;
  logic               busy;

  int                 a_mem [1024][NM];
  int                 b_mem [1024];
  logic [NM*DW-1:0]   exp_o;
  logic               exp_ovf;
  int                 total;
  int                 bad;

  pe_v3 dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_mode (cfg_mode),
    .cfg_k    (cfg_k),
    .cfg_shift(cfg_shift),
    .cfg_err  (cfg_err),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_packed (a_packed),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .o_packed (o_packed),
    .ovf      (ovf),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string tag, input logic signed [63:0] obs,
                            input logic signed [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkVector(input string tag, input logic [NM*DW-1:0] obs,
                             input logic [NM*DW-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: each lane is an integer accumulator clamped to the
  // accumulator range, then rounded, divided by 2^shift (floor) and clamped
  // to the output range.
  function automatic void computeModel(input int mode, input int k, input int shift);
    exp_ovf = 1'b0;
    for (int j = 0; j < NM; j++) begin
      longint acc;
      longint v;
      longint r;
      acc = (mode == 2) ? OUT_LO : 0;
      for (int i = 0; i < k; i++) begin
        v = a_mem[i][j];
        if (mode == 0) v = v * b_mem[i];
        if (mode == 2) begin
          if (v > acc) acc = v;
        end else begin
          acc = acc + v;
          if (acc > ACC_HI) begin acc = ACC_HI; exp_ovf = 1'b1; end
          if (acc < ACC_LO) begin acc = ACC_LO; exp_ovf = 1'b1; end
        end
      end
      if (shift == 0) r = acc;
      else r = (acc + (longint'(1) << (shift - 1))) >>> shift;
      if (r > OUT_HI) begin r = OUT_HI; exp_ovf = 1'b1; end
      if (r < OUT_LO) begin r = OUT_LO; exp_ovf = 1'b1; end
      exp_o[j*DW +: DW] = DW'(r);
    end
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(255)) - 128;
  endfunction

  task automatic fillRandom(input int k);
    for (int i = 0; i < k; i++) begin
      for (int j = 0; j < NM; j++) a_mem[i][j] = rnd8();
      b_mem[i] = rnd8();
    end
  endtask

  task automatic driveBeat(input int idx);
    for (int j = 0; j < NM; j++) a_packed[j*DW +: DW] = DW'(a_mem[idx][j]);
    b = DW'(b_mem[idx]);
  endtask

  task automatic checkResetState(input string tag);
    checkValue({tag, "_cfg_ready"}, cfg_ready, 1);
    checkValue({tag, "_in_ready"}, in_ready, 0);
    checkValue({tag, "_out_valid"}, out_valid, 0);
    checkValue({tag, "_cfg_err"}, cfg_err, 0);
    checkValue({tag, "_ovf"}, ovf, 0);
    checkValue({tag, "_busy"}, busy, 0);
    checkVector({tag, "_o_packed"}, o_packed, '0);
  endtask

  // Runs config and all beats of one job from a_mem/b_mem, with random
  // in_valid gaps, and checks the handshake timing up to out_valid.
  task automatic applyStimulus(input string tag, input int mode, input int k,
                               input int shift, input int gap_pct);
    int idx;
    computeModel(mode, k, shift);
    cfg_valid = 1'b1;
    cfg_mode  = 2'(mode);
    cfg_k     = KW'(k);
    cfg_shift = SW'(shift);
    checkValue({tag, "_cfg_ready"}, cfg_ready, 1);
    cycle();
    cfg_valid = 1'b0;
    checkValue({tag, "_in_ready_start"}, in_ready, 1);
    checkValue({tag, "_busy"}, busy, 1);
    idx = 0;
    while (idx < k) begin
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        for (int w = 0; w < NM*DW/32; w++) a_packed[w*32 +: 32] = $urandom;
        b = DW'($urandom);
      end else begin
        in_valid = 1'b1;
        driveBeat(idx);
        idx++;
      end
      cycle();
    end
    in_valid = 1'b0;
    checkValue({tag, "_in_ready_end"}, in_ready, 0);
    checkValue({tag, "_out_valid_early"}, out_valid, 0);
    cycle();
    checkValue({tag, "_out_valid_latency"}, out_valid, 1);
  endtask

  // Holds out_ready low for 'hold' cycles (optionally with a stray illegal
  // config), then checks the result and completes the output handshake.
  task automatic checkOutput(input string tag, input int hold, input bit cfg_noise);
    out_ready = 1'b0;
    if (hold > 0) begin
      cfg_valid = cfg_noise;
      cfg_mode  = 2'd3;
      cfg_k     = '0;
      for (int c = 0; c < hold; c++) begin
        cycle();
        checkVector({tag, "_hold_o"}, o_packed, exp_o);
      end
      checkValue({tag, "_hold_cfg_ready"}, cfg_ready, 0);
      checkValue({tag, "_hold_out_valid"}, out_valid, 1);
      checkValue({tag, "_hold_cfg_err"}, cfg_err, 0);
      cfg_valid = 1'b0;
    end
    checkVector({tag, "_o"}, o_packed, exp_o);
    checkValue({tag, "_ovf"}, ovf, exp_ovf);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    checkValue({tag, "_out_valid_after"}, out_valid, 0);
    checkValue({tag, "_cfg_ready_after"}, cfg_ready, 1);
    checkValue({tag, "_busy_after"}, busy, 0);
    checkValue({tag, "_ovf_after"}, ovf, exp_ovf);
  endtask

  task automatic illegalConfig(input string tag, input int mode, input int k);
    cfg_valid = 1'b1;
    cfg_mode  = 2'(mode);
    cfg_k     = KW'(k);
    cfg_shift = '0;
    cycle();
    cfg_valid = 1'b0;
    checkValue({tag, "_err_pulse"}, cfg_err, 1);
    checkValue({tag, "_busy"}, busy, 0);
    checkValue({tag, "_in_ready"}, in_ready, 0);
    cycle();
    checkValue({tag, "_err_clear"}, cfg_err, 0);
    checkValue({tag, "_busy_still"}, busy, 0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_mode  = '0;
    cfg_k     = '0;
    cfg_shift = '0;
    in_valid  = 1'b0;
    a_packed  = '0;
    b         = '0;
    out_ready = 1'b0;

    // Reset values
    cycle();
    checkResetState("reset");
    rst = 1'b0;
    cycle();

    // MACC k=3 shift=0, a_j = j-32, b = 2
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < NM; j++) a_mem[i][j] = j - 32;
      b_mem[i] = 2;
    end
    applyStimulus("macc", 0, 3, 0, 0);
    checkValue("macc_lane0", $signed(o_packed[0*DW +: DW]), -128);
    checkValue("macc_lane40", $signed(o_packed[40*DW +: DW]), 48);
    checkValue("macc_lane63", $signed(o_packed[63*DW +: DW]), 127);
    checkValue("macc_ovf_set", ovf, 1);
    checkOutput("macc", 0, 1'b0);

    // ADD k=4 shift=2 with round-half-up on lanes 0 and 1
    fillRandom(4);
    a_mem[0][0] = 1;  a_mem[1][0] = 1;  a_mem[2][0] = 1;  a_mem[3][0] = 2;
    for (int i = 0; i < 4; i++) a_mem[i][1] = -1;
    applyStimulus("add", 1, 4, 2, 0);
    checkValue("add_lane0", $signed(o_packed[0*DW +: DW]), 1);
    checkValue("add_lane1", $signed(o_packed[1*DW +: DW]), -1);
    checkOutput("add", 0, 1'b0);

    // MAX k=5 shift=0
    fillRandom(5);
    a_mem[0][0] = -128; a_mem[1][0] = -7; a_mem[2][0] = 3;
    a_mem[3][0] = -1;   a_mem[4][0] = 2;
    for (int i = 0; i < 5; i++) a_mem[i][1] = -128;
    applyStimulus("max", 2, 5, 0, 0);
    checkValue("max_lane0", $signed(o_packed[0*DW +: DW]), 3);
    checkValue("max_lane1", $signed(o_packed[1*DW +: DW]), -128);
    checkValue("max_ovf_clear", ovf, 0);
    checkOutput("max", 0, 1'b0);

    // Back-pressure with input gaps and a stray config while busy
    fillRandom(7);
    applyStimulus("bp", 0, 7, 6, 40);
    checkOutput("bp", 10, 1'b1);

    // Illegal configs, then a legal job
    illegalConfig("ill_mode", 3, 5);
    illegalConfig("ill_k0", 0, 0);
    fillRandom(6);
    applyStimulus("post_ill", 1, 6, 1, 20);
    checkOutput("post_ill", 0, 1'b0);

    // Reset mid-ACCUM after 2 of 8 beats
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < NM; j++) a_mem[i][j] = 127;
      b_mem[i] = 127;
    end
    cfg_valid = 1'b1;
    cfg_mode  = 2'd0;
    cfg_k     = KW'(8);
    cfg_shift = SW'(0);
    cycle();
    cfg_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      driveBeat(i);
      cycle();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checkResetState("midrst");
    fillRandom(4);
    applyStimulus("fresh", 1, 4, 0, 0);
    checkOutput("fresh", 0, 1'b0);

    // Random jobs
    for (int n = 0; n < 8; n++) begin
      int m;
      int k;
      int s;
      m = int'($urandom_range(2));
      k = int'($urandom_range(12, 1));
      s = int'($urandom_range(10));
      fillRandom(k);
      applyStimulus("rand", m, k, s, 30);
      checkOutput("rand", int'($urandom_range(3)), 1'b0);
    end

    // Maximum beat count with accumulator saturation on even lanes
    for (int i = 0; i < 1023; i++) begin
      for (int j = 0; j < NM; j++) a_mem[i][j] = (j % 2 == 0) ? 127 : rnd8();
      b_mem[i] = 127;
    end
    applyStimulus("kmax", 0, 1023, 16, 10);
    checkValue("kmax_lane0", $signed(o_packed[0*DW +: DW]), 127);
    checkOutput("kmax", 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
